// File: rtl/alu_logic_pkg.sv
// Shared types for the pipelined bitwise logic unit: opcode encoding,
// flag payload and legal parameter bounds.
package alu_logic_pkg;

  localparam int LOP_MIN_W      = 8;
  localparam int LOP_MAX_W      = 64;
  localparam int LOP_MIN_STAGES = 1;
  localparam int LOP_MAX_STAGES = 4;

  typedef enum logic [2:0] {
    LOP_AND    = 3'd0,
    LOP_OR     = 3'd1,
    LOP_XOR    = 3'd2,
    LOP_NOR    = 3'd3,
    LOP_BIC    = 3'd4,
    LOP_XNOR   = 3'd5,
    LOP_PASS_A = 3'd6,
    LOP_NOT_B  = 3'd7
  } logic_op_e;

  // Width-independent part of a slice payload; the result field is added
  // by the pipe, which knows DATA_WIDTH.
  typedef struct packed {
    logic zero;
    logic negative;
  } flag_t;

endpackage

// File: rtl/alu_logic_slice.sv
// One pipeline slice: a valid bit plus an opaque payload word, loaded or
// emptied under control of the pipe's ready chain.
module alu_logic_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] pay_i,
  output logic         valid_o,
  output logic [W-1:0] pay_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] pay_q, pay_d;

  // Payload only moves on a real load, so an emptied slice keeps its last word.
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (load_i) begin
      valid_d = 1'b1;
      pay_d   = pay_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign valid_o = valid_q;
  assign pay_o   = pay_q;

endmodule

// File: rtl/alu_logic_pipe.sv
// Pipelined eight-function bitwise logic unit with zero/negative flags and
// a valid/ready handshake; STAGES slices between operands and result.
module alu_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  negative
);

  if (DATA_WIDTH < LOP_MIN_W || DATA_WIDTH > LOP_MAX_W) begin : g_bad_width
    $fatal(1, "alu_logic_pipe: DATA_WIDTH=%0d outside 8..64", DATA_WIDTH);
  end
  if (STAGES < LOP_MIN_STAGES || STAGES > LOP_MAX_STAGES) begin : g_bad_stages
    $fatal(1, "alu_logic_pipe: STAGES=%0d outside 1..4", STAGES);
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    flag_t                 flags;
  } pay_t;

  localparam int PW = $bits(pay_t);

  function automatic logic [DATA_WIDTH-1:0] apply_op(
    input logic_op_e             o,
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] y
  );
    logic [DATA_WIDTH-1:0] r;
    case (o)
      LOP_AND:    r = x & y;
      LOP_OR:     r = x | y;
      LOP_XOR:    r = x ^ y;
      LOP_NOR:    r = ~(x | y);
      LOP_BIC:    r = x & ~y;
      LOP_XNOR:   r = ~(x ^ y);
      LOP_PASS_A: r = x;
      LOP_NOT_B:  r = ~y;
      default:    r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] res_d;
  pay_t                  pay_d;
  pay_t                  out_pay;
  logic [STAGES-1:0]     stg_vld;
  logic [STAGES-1:0]     stg_en;
  logic [PW-1:0]         stg_pay [STAGES];

  // Function select and flags, ahead of slice 0
  always_comb begin
    res_d                = apply_op(logic_op_e'(op), A, B);
    pay_d.result         = res_d;
    pay_d.flags.zero     = ~|res_d;
    pay_d.flags.negative = res_d[DATA_WIDTH-1];
  end

  // Ready chain: a slice may load when empty or when its contents move on
  // this cycle; evaluated from the consumer back to the producer.
  always_comb begin
    logic [STAGES-1:0] take;
    take             = '0;
    stg_en           = '0;
    take[STAGES-1]   = stg_vld[STAGES-1] & out_ready;
    for (int k = STAGES - 1; k >= 1; k--) begin
      stg_en[k]    = ~stg_vld[k] | take[k];
      take[k-1]    = stg_vld[k-1] & stg_en[k];
    end
    stg_en[0] = ~stg_vld[0] | take[0];
  end

  assign in_ready = stg_en[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic          up_vld;
    logic [PW-1:0] up_pay;

    if (k == 0) begin : g_head
      assign up_vld = in_valid;
      assign up_pay = pay_d;
    end else begin : g_body
      assign up_vld = stg_vld[k-1];
      assign up_pay = stg_pay[k-1];
    end

    // Slice k boundary
    alu_logic_slice #(.W(PW)) u_slice (
      .clk     (clk),
      .reset   (reset),
      .load_i  (stg_en[k] & up_vld),
      .clear_i (stg_en[k] & ~up_vld),
      .pay_i   (up_pay),
      .valid_o (stg_vld[k]),
      .pay_o   (stg_pay[k])
    );
  end

  assign out_pay   = stg_pay[STAGES-1];
  assign out_valid = stg_vld[STAGES-1];
  assign result    = out_pay.result;
  assign zero      = out_pay.flags.zero;
  assign negative  = out_pay.flags.negative;

endmodule
